// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: multiplexed segment bus inputs and decoded frame outputs
interface seg_scan_decoder_if;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [3:0]  dig_in;
    logic [15:0] digits_out;
    logic [3:0]  blank_out;
    logic        colon_out;
    logic        frame_valid;
    logic        seg_err;
    logic        bus_err;
    modport master (
        output seg_in, dp_in, dig_in,
        input  digits_out, blank_out, colon_out, frame_valid, seg_err, bus_err
    );
    modport slave (
        input  seg_in, dp_in, dig_in,
        output digits_out, blank_out, colon_out, frame_valid, seg_err, bus_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a scanned 4-digit 7-segment bus and publishes debounced digit frames
module seg_scan_decoder #(
    parameter int SETTLE         = 4,
    parameter int MATCH_FRAMES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic               clock,
    input logic               reset,
    seg_scan_decoder_if.slave bus
);
    logic [6:0]  seg_m, seg_s, seg_p, seg_v;
    logic        dp_m, dp_s, dp_v;
    logic [3:0]  dig_m, dig_s, dig_p;
    logic [3:0]  cnt, seen, seen_nx, blk_sh, blk_nx, prev_blk, mcnt, mcnt_nx, value;
    logic [15:0] val_sh, val_nx, prev_val;
    logic [1:0]  idx;
    logic        colon_acc, err_acc, colon_nx, err_nx, published;
    logic        changed, multi, multi_p, one_hot, sample, complete, publish, undec, blank;

    assign seg_v    = SEG_ACTIVE_LOW ? ~seg_s : seg_s;
    assign dp_v     = SEG_ACTIVE_LOW ? ~dp_s : dp_s;
    assign multi    = |(dig_s & (dig_s - 4'd1));
    assign multi_p  = |(dig_p & (dig_p - 4'd1));
    assign one_hot  = |dig_s && !multi;
    assign changed  = seg_s != seg_p || dig_s != dig_p;
    assign sample   = !changed && one_hot && cnt == 4'(SETTLE - 1);
    assign idx      = dig_s[3] ? 2'd3 : dig_s[2] ? 2'd2 : dig_s[1] ? 2'd1 : 2'd0;
    assign colon_nx = colon_acc | (sample & dp_v);
    assign err_nx   = err_acc | (sample & undec);

    always_comb begin
        value = 4'h0;
        blank = 1'b0;
        undec = 1'b0;
        case (seg_v)
            7'h3F:        value = 4'd0;
            7'h06:        value = 4'd1;
            7'h5B:        value = 4'd2;
            7'h4F:        value = 4'd3;
            7'h66:        value = 4'd4;
            7'h6D:        value = 4'd5;
            7'h7D, 7'h7C: value = 4'd6;
            7'h07, 7'h27: value = 4'd7;
            7'h7F:        value = 4'd8;
            7'h6F, 7'h67: value = 4'd9;
            7'h00:        blank = 1'b1;
            default: begin
                value = 4'hF;
                undec = 1'b1;
            end
        endcase
    end

    // Frame bookkeeping works on the post-write shadow so sample, completion and publish share one edge
    always_comb begin
        val_nx  = val_sh;
        blk_nx  = blk_sh;
        seen_nx = seen;
        if (sample) begin
            val_nx[{idx, 2'b00} +: 4] = value;
            blk_nx[idx]  = blank;
            seen_nx[idx] = 1'b1;
        end
        complete = sample && seen_nx == 4'hF;
        mcnt_nx  = {val_nx, blk_nx} != {prev_val, prev_blk} ? 4'd1 :
                   mcnt >= 4'(MATCH_FRAMES) ? 4'(MATCH_FRAMES) : mcnt + 4'd1;
        publish  = complete && mcnt_nx >= 4'(MATCH_FRAMES) &&
                   ({val_nx, blk_nx} != {bus.digits_out, bus.blank_out} || !published);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {seg_m, seg_s, seg_p, dp_m, dp_s, dig_m, dig_s, dig_p} <= '0;
            {cnt, seen, mcnt, val_sh, blk_sh, prev_val, prev_blk} <= '0;
            {colon_acc, err_acc, published} <= '0;
            bus.digits_out  <= '0;
            bus.blank_out   <= 4'hF;
            bus.colon_out   <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.seg_err     <= 1'b0;
            bus.bus_err     <= 1'b0;
        end else begin
            seg_m <= bus.seg_in;
            seg_s <= seg_m;
            seg_p <= seg_s;
            dp_m  <= bus.dp_in;
            dp_s  <= dp_m;
            dig_m <= bus.dig_in;
            dig_s <= dig_m;
            dig_p <= dig_s;
            cnt   <= (changed || !one_hot) ? 4'd0 : cnt == 4'(SETTLE) ? cnt : cnt + 4'd1;
            bus.bus_err     <= multi && !multi_p;
            bus.frame_valid <= publish;
            val_sh    <= val_nx;
            blk_sh    <= blk_nx;
            seen      <= complete ? 4'h0 : seen_nx;
            colon_acc <= !complete && colon_nx;
            err_acc   <= !complete && err_nx;
            bus.seg_err <= complete ? err_nx : bus.seg_err | (sample & undec);
            if (complete) begin
                prev_val      <= val_nx;
                prev_blk      <= blk_nx;
                mcnt          <= mcnt_nx;
                bus.colon_out <= colon_nx;
            end
            if (publish) begin
                bus.digits_out <= val_nx;
                bus.blank_out  <= blk_nx;
                published      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench driving scanned frames and checking against a frame-level model
module tb_seg_scan_decoder;
    localparam int SETTLE = 4;
    localparam int MATCH  = 2;

    logic clock = 1'b0;
    logic reset;
    seg_scan_decoder_if bus();

    seg_scan_decoder #(.SETTLE(SETTLE), .MATCH_FRAMES(MATCH), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  b;
    } frame_t;

    frame_t exp_q[$];
    frame_t hist[$];
    frame_t pub, mon_e;
    bit     pubd = 1'b0;
    int     total = 0, bad = 0, bus_pulses = 0;
    frame_t pool[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Codes 0..9 are digits, 10 an undecodable pattern, 11 a blank digit
    function automatic logic [6:0] pat(input logic [3:0] c);
        case (c)
            4'd0:  return 7'h3F;
            4'd1:  return 7'h06;
            4'd2:  return 7'h5B;
            4'd3:  return 7'h4F;
            4'd4:  return 7'h66;
            4'd5:  return 7'h6D;
            4'd6:  return $urandom_range(1) ? 7'h7D : 7'h7C;
            4'd7:  return $urandom_range(1) ? 7'h07 : 7'h27;
            4'd8:  return 7'h7F;
            4'd9:  return $urandom_range(1) ? 7'h6F : 7'h67;
            4'd11: return 7'h00;
            default: return $urandom_range(1) ? 7'h49 : 7'h76;
        endcase
    endfunction

    task automatic drive(input logic [3:0] dig, input logic [6:0] seg, input logic dp, input int cycles);
        bus.dig_in = dig;
        bus.seg_in = seg;
        bus.dp_in  = dp;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic check_reset();
        check("rst_digits", 32'(bus.digits_out), 32'h0);
        check("rst_blank", 32'(bus.blank_out), 32'hF);
        check("rst_colon", 32'(bus.colon_out), 32'h0);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'h0);
        check("rst_seg_err", 32'(bus.seg_err), 32'h0);
        check("rst_bus_err", 32'(bus.bus_err), 32'h0);
    endtask

    // Dwell of 3 never settles; dwells used otherwise are >= 8 so every slot is sampled in its dwell
    task automatic send_frame(input logic [15:0] codes, input logic [3:0] dps, input int dwell,
                              input bit gaps, input bit inject_bus);
        frame_t     f;
        logic [3:0] c;
        bit         err = 1'b0;
        bit         same = 1'b1;
        bit         sampled = dwell >= SETTLE + 3;
        int         b0;
        for (int i = 0; i < 4; i++) begin
            c = codes[i*4 +: 4];
            f.d[i*4 +: 4] = c < 4'd10 ? c : (c == 4'd11 ? 4'h0 : 4'hF);
            f.b[i] = c == 4'd11;
            err |= c == 4'd10;
        end
        if (sampled) begin
            hist.push_back(f);
            if (hist.size() > MATCH) void'(hist.pop_front());
            foreach (hist[k]) same &= hist[k] == f;
            if (hist.size() == MATCH && same && (!pubd || pub != f)) begin
                exp_q.push_back(f);
                pub  = f;
                pubd = 1'b1;
            end
        end
        b0 = bus_pulses;
        for (int i = 3; i >= 0; i--) begin
            c = codes[i*4 +: 4];
            drive(4'(1 << i), pat(c), dps[i], dwell);
            if (c == 4'd10 && sampled) check("seg_err_immediate", 32'(bus.seg_err), 32'h1);
            if (gaps && $urandom_range(1) == 1) drive(4'h0, 7'h00, 1'b0, $urandom_range(1, 3));
            if (inject_bus && i == 2) begin
                drive(4'b0110, 7'h49, 1'b1, 10);
                check("bus_err_pulses", 32'(bus_pulses - b0), 32'h1);
                check("bus_err_no_sample", 32'(bus.seg_err), 32'h0);
            end
        end
        if (sampled) begin
            check("colon", 32'(bus.colon_out), 32'(|dps));
            check("seg_err_frame", 32'(bus.seg_err), 32'(err));
        end else drive(4'h0, 7'h00, 1'b0, 1);
    endtask

    always @(negedge clock) begin
        if (bus.bus_err) bus_pulses++;
        if (bus.frame_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_valid: got digits %0h blank %0h expected no pulse",
                         bus.digits_out, bus.blank_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame_digits", 32'(bus.digits_out), 32'(mon_e.d));
                check("frame_blank", 32'(bus.blank_out), 32'(mon_e.b));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.dig_in = 4'h0;
        bus.seg_in = 7'h00;
        bus.dp_in  = 1'b0;
        repeat (3) @(negedge clock);
        check_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        // Stable scan then unchanged repeat
        repeat (3) send_frame(16'h1234, 4'h0, 8, 1'b0, 1'b0);
        check("stable_digits", 32'(bus.digits_out), 32'h1234);
        // Change, then a single glitch frame between good frames
        repeat (2) send_frame(16'h1235, 4'h0, 8, 1'b0, 1'b0);
        send_frame(16'h1235, 4'h0, 8, 1'b0, 1'b0);
        send_frame(16'h9999, 4'h0, 8, 1'b0, 1'b0);
        send_frame(16'h1235, 4'h0, 8, 1'b0, 1'b0);
        check("glitch_ignored", 32'(bus.digits_out), 32'h1235);
        // Short dwell never samples
        repeat (2) send_frame(16'h5678, 4'h0, 3, 1'b0, 1'b0);
        check("short_dwell", 32'(bus.digits_out), 32'h1235);
        // Blank leftmost digit
        repeat (2) send_frame(16'hB123, 4'h0, 8, 1'b0, 1'b0);
        check("blank_flags", 32'(bus.blank_out), 32'h8);
        check("blank_digit", 32'(bus.digits_out[15:12]), 32'h0);
        // Undecodable pattern on digit 1, then a clean frame, then a multi-hot hold mid-frame
        repeat (2) send_frame(16'h12A4, 4'h0, 8, 1'b0, 1'b0);
        check("err_digit", 32'(bus.digits_out[7:4]), 32'hF);
        send_frame(16'h1234, 4'h0, 8, 1'b0, 1'b0);
        send_frame(16'h1234, 4'h0, 8, 1'b0, 1'b1);
        // Colon alternating per frame does not disturb matching
        for (int k = 0; k < 4; k++) send_frame(16'h4321, k % 2 == 0 ? 4'b0100 : 4'b0000, 8, 1'b0, 1'b0);
        // Random frames from a small pool so repeats occur
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 4; i++) begin
                pool[p].d[i*4 +: 4] = $urandom_range(15) == 0 ? 4'd10 :
                                      $urandom_range(9) == 0 ? 4'd11 : 4'($urandom_range(9));
                pool[p].b[i] = 1'b0;
            end
        for (int n = 0; n < 25; n++) begin
            int sel = $urandom_range(3);
            int reps = $urandom_range(1, 3);
            for (int r = 0; r < reps; r++)
                send_frame(pool[sel].d, 4'($urandom_range(15)), $urandom_range(8, 11), 1'b1, 1'b0);
        end
        // Reset mid-frame after three slots
        drive(4'b1000, pat(4'd1), 1'b0, 8);
        drive(4'b0100, pat(4'd2), 1'b1, 8);
        drive(4'b0010, pat(4'd3), 1'b0, 8);
        reset = 1'b0;
        bus.dig_in = 4'h0;
        #1;
        check_reset();
        hist.delete();
        pubd = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        send_frame(16'h1234, 4'h0, 8, 1'b0, 1'b0);
        check("post_reset_hold", 32'(bus.digits_out), 32'h0);
        send_frame(16'h1234, 4'h0, 8, 1'b0, 1'b0);
        repeat (20) @(negedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("bus_err_total", 32'(bus_pulses), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
